// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FSM states, the NOP used to fill IF/ID, and the default boot address.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus with hold-until-ready handshake.
// The fetch unit is the master; the memory side is the slave.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_target_mux.sv
// Redirect target select: JALR clears bit 0, branch/JAL target passes through.
// Also flags a target that is not 4-byte aligned (bit 1 set).
module fetch_target_mux #(
  parameter int XLEN = 32
) (
  input  logic            jalr_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  always_comb begin
    target_o     = jalr_i ? {jalr_target_i[XLEN-1:1], 1'b0} : branch_target_i;
    misaligned_o = target_o[1];
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, drives the imem handshake,
// handles EX redirects and load-use stalls with a one-entry hold buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mpc,
  input  logic              jalr,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [XLEN-1:0]   jalr_target,
  input  logic              stall,
  fetch_unit_if.master      imem,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [XLEN-1:0]   if_pc,
  output logic              flush,
  output logic              misaligned
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic            hold_vld_q, hold_vld_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] target;
  logic            target_mis;
  logic [XLEN-1:0] seq_addr;
  logic            if_load;
  logic            if_load_vld;
  logic [31:0]     if_load_instr;
  logic [XLEN-1:0] if_load_pc;

  fetch_target_mux #(.XLEN(XLEN)) u_target_mux (
    .jalr_i          (jalr),
    .branch_target_i (branch_target),
    .jalr_target_i   (jalr_target),
    .target_o        (target),
    .misaligned_o    (target_mis)
  );

  // Wraps modulo 2^XLEN by construction.
  assign seq_addr = req_addr_q + PC_STEP;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    hold_vld_d    = hold_vld_q;
    if_load       = 1'b0;
    if_load_vld   = 1'b0;
    if_load_instr = if_instr_q;
    if_load_pc    = if_pc_q;
    misaligned_d  = mpc & target_mis;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (mpc) begin
          pc_d       = target;
          req_addr_d = target;
        end
      end

      ST_FETCH: begin
        if (mpc) begin
          pc_d = target;
          if (imem.imem_ready) req_addr_d = target;
          else                 state_d    = ST_DRAIN;
        end else if (imem.imem_ready) begin
          pc_d = seq_addr;
          if (stall) begin
            // IF/ID is frozen; park the returning word until it frees up.
            hold_instr_d = imem.imem_rdata;
            hold_pc_d    = req_addr_q;
            hold_vld_d   = 1'b1;
            state_d      = ST_HOLD;
          end else begin
            req_addr_d    = seq_addr;
            if_load       = 1'b1;
            if_load_vld   = 1'b1;
            if_load_instr = imem.imem_rdata;
            if_load_pc    = req_addr_q;
          end
        end
      end

      ST_DRAIN: begin
        // The old request cannot be withdrawn; wait it out, latest target wins.
        if (mpc) pc_d = target;
        if (imem.imem_ready) begin
          req_addr_d = mpc ? target : pc_q;
          state_d    = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (mpc) begin
          pc_d       = target;
          req_addr_d = target;
          hold_vld_d = 1'b0;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          if_load       = 1'b1;
          if_load_vld   = hold_vld_q;
          if_load_instr = hold_instr_q;
          if_load_pc    = hold_pc_q;
          hold_vld_d    = 1'b0;
          req_addr_d    = pc_q;
          state_d       = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // IF outputs: a redirect kills, a stall freezes, otherwise load or go empty.
  always_comb begin
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if (mpc) begin
      if_valid_d = 1'b0;
    end else if (if_load) begin
      if_valid_d = if_load_vld;
      if_instr_d = if_load_instr;
      if_pc_d    = if_load_pc;
    end else if (!stall) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      hold_vld_q   <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_vld_q   <= hold_vld_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  // DRAIN keeps the request asserted so the old transfer can complete.
  assign imem.imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem.imem_addr = req_addr_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign flush          = mpc;
  assign misaligned     = misaligned_q;

endmodule
